// File: rtl/paint_pkg.sv
// paint_pkg: shared widths and fill FSM encoding for the paint-board blocks
package paint_pkg;
  localparam int CW = 8;
  localparam int DW = 12;
  localparam int ADDR_W = 2 * CW;
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} fill_st_t;
endpackage

// File: rtl/rect_scan_cnt.sv
// rect_scan_cnt: latched rectangle bounds and column-major scan cursor
module rect_scan_cnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          adv,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] y1,
  output logic [CW-1:0] cur_x,
  output logic [CW-1:0] cur_y,
  output logic          last
);
  logic [CW-1:0] xh, yl, yh;
  assign last = cur_x == xh && cur_y == yh;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      xh    <= '0;
      yl    <= '0;
      yh    <= '0;
      cur_x <= '0;
      cur_y <= '0;
    end else if (load) begin
      xh    <= x0 > x1 ? x0 : x1;
      yl    <= y0 < y1 ? y0 : y1;
      yh    <= y0 > y1 ? y0 : y1;
      cur_x <= x0 < x1 ? x0 : x1;
      cur_y <= y0 < y1 ? y0 : y1;
    end else if (adv) begin
      cur_y <= cur_y == yh ? yl : cur_y + 1'b1;
      cur_x <= cur_y == yh ? cur_x + 1'b1 : cur_x;
    end
endmodule

// File: rtl/vram_write_sched.sv
// vram_write_sched: VRAM write-port arbiter, pen has priority over the rectangle fill
module vram_write_sched
  import paint_pkg::*;
#(
  parameter int CW = paint_pkg::CW,
  parameter int DW = paint_pkg::DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pen_req,
  input  logic [2*CW-1:0] pen_addr,
  input  logic [DW-1:0]   pen_data,
  output logic            pen_ack,
  input  logic            fill_start,
  input  logic            fill_abort,
  input  logic [CW-1:0]   fill_x0,
  input  logic [CW-1:0]   fill_x1,
  input  logic [CW-1:0]   fill_y0,
  input  logic [CW-1:0]   fill_y1,
  input  logic [DW-1:0]   fill_color,
  output logic            fill_busy,
  output logic            fill_done,
  output logic            fill_aborted,
  output logic            vram_we,
  output logic [2*CW-1:0] vram_addr,
  output logic [DW-1:0]   vram_data
);
  fill_st_t state, state_nx;
  logic load, fill_grant, last, abort_q;
  logic [CW-1:0] cur_x, cur_y;
  logic [DW-1:0] color_q;
  rect_scan_cnt #(.CW(CW)) u_scan (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .adv   (fill_grant),
    .x0    (fill_x0),
    .x1    (fill_x1),
    .y0    (fill_y0),
    .y1    (fill_y1),
    .cur_x (cur_x),
    .cur_y (cur_y),
    .last  (last)
  );
  always_comb begin
    load         = state == ST_IDLE && fill_start;
    fill_grant   = state == ST_FILL && !pen_req && !fill_abort;
    pen_ack      = pen_req && !rst;
    fill_busy    = state == ST_FILL;
    fill_done    = state == ST_DONE;
    fill_aborted = fill_done && abort_q;
    state_nx     = state == ST_IDLE ? (fill_start ? ST_FILL : ST_IDLE) :
                   state == ST_FILL ? ((fill_abort || (fill_grant && last)) ? ST_DONE : ST_FILL) :
                   ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= ST_IDLE;
      abort_q   <= 1'b0;
      color_q   <= '0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
    end else begin
      state     <= state_nx;
      abort_q   <= state == ST_FILL && fill_abort;
      color_q   <= load ? fill_color : color_q;
      vram_we   <= pen_req || fill_grant;
      vram_addr <= pen_req ? pen_addr : {cur_x, cur_y};
      vram_data <= pen_req ? pen_data : color_q;
    end
endmodule

// File: tb/tb_vram_write_sched.sv
// tb_vram_write_sched: model-checked directed bench for the VRAM write scheduler
module tb_vram_write_sched;
  logic        clk = 0, rst = 1;
  logic        pen_req = 0, fill_start = 0, fill_abort = 0;
  logic [15:0] pen_addr = 0;
  logic [11:0] pen_data = 0, fill_color = 0;
  logic [7:0]  fill_x0 = 0, fill_x1 = 0, fill_y0 = 0, fill_y1 = 0;
  logic        pen_ack, fill_busy, fill_done, fill_aborted, vram_we;
  logic [15:0] vram_addr;
  logic [11:0] vram_data;
  int n_chk = 0, n_fail = 0;
  logic [15:0] wlog[$];
  vram_write_sched dut (
    .clk(clk), .rst(rst), .pen_req(pen_req), .pen_addr(pen_addr), .pen_data(pen_data),
    .pen_ack(pen_ack), .fill_start(fill_start), .fill_abort(fill_abort),
    .fill_x0(fill_x0), .fill_x1(fill_x1), .fill_y0(fill_y0), .fill_y1(fill_y1),
    .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done),
    .fill_aborted(fill_aborted), .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: a fill is a list of w*h pixels in column-major order; pixel k sits at (xl+k/h, yl+k%h)
  int ph, k, npix, h;
  int xl, yl;
  logic [11:0] col;
  logic ab, m_we;
  logic [15:0] m_addr;
  logic [11:0] m_data;
  always @(posedge clk or posedge rst)
    if (rst) begin
      ph <= 0; ab <= 0; m_we <= 0; m_addr <= 0; m_data <= 0; k <= 0;
    end else begin
      m_we <= 0;
      if (pen_req) begin
        m_we <= 1; m_addr <= pen_addr; m_data <= pen_data;
      end else if (ph == 1 && !fill_abort) begin
        m_we <= 1;
        m_addr <= {8'(xl + k / h), 8'(yl + k % h)};
        m_data <= col;
        k <= k + 1;
      end
      if (ph == 0 && fill_start) begin
        xl <= fill_x0 < fill_x1 ? int'(fill_x0) : int'(fill_x1);
        yl <= fill_y0 < fill_y1 ? int'(fill_y0) : int'(fill_y1);
        h <= (fill_y0 > fill_y1 ? fill_y0 - fill_y1 : fill_y1 - fill_y0) + 1;
        npix <= ((fill_x0 > fill_x1 ? int'(fill_x0) - int'(fill_x1) : int'(fill_x1) - int'(fill_x0)) + 1)
              * ((fill_y0 > fill_y1 ? int'(fill_y0) - int'(fill_y1) : int'(fill_y1) - int'(fill_y0)) + 1);
        col <= fill_color; k <= 0; ab <= 0; ph <= 1;
      end else if (ph == 1) begin
        if (fill_abort) begin ph <= 2; ab <= 1; end
        else if (!pen_req && k + 1 == npix) ph <= 2;
      end else if (ph == 2) ph <= 0;
    end
  always @(negedge clk) begin
    chk("pen_ack", pen_ack, pen_req && !rst);
    chk("vram_we", vram_we, m_we);
    if (m_we) begin
      chk("vram_addr", vram_addr, m_addr);
      chk("vram_data", vram_data, m_data);
    end
    chk("fill_busy", fill_busy, ph == 1);
    chk("fill_done", fill_done, ph == 2);
    chk("fill_aborted", fill_aborted, ph == 2 && ab);
    if (vram_we && !rst) wlog.push_back(vram_addr);
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic start_fill(input logic [7:0] x0, x1, y0, y1, input logic [11:0] c);
    fill_x0 = x0; fill_x1 = x1; fill_y0 = y0; fill_y1 = y1; fill_color = c; fill_start = 1;
    step(1);
    fill_start = 0;
  endtask
  task automatic wait_done(input int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      @(negedge clk); #1;
      if (fill_done) break;
    end
    chk("done_in_time", i < lim, 1);
  endtask
  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    #1;
    chk("rst_we", vram_we, 0);
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_addr", vram_addr, 0);
    step(1);
    // pen only
    pen_req = 1; pen_addr = 16'h8080; pen_data = 12'hF00;
    #1 chk("t1_ack", pen_ack, 1);
    step(1);
    pen_req = 0;
    #1;
    chk("t1_we", vram_we, 1);
    chk("t1_addr", vram_addr, 16'h8080);
    chk("t1_data", vram_data, 12'hF00);
    step(2);
    // small fill with swapped y bounds
    wlog.delete();
    start_fill(2, 3, 5, 4, 12'h0F0);
    wait_done(20);
    chk("t2_aborted", fill_aborted, 0);
    chk("t2_n", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("t2_w0", wlog[0], 16'h0204);
      chk("t2_w1", wlog[1], 16'h0205);
      chk("t2_w2", wlog[2], 16'h0304);
      chk("t2_w3", wlog[3], 16'h0305);
    end
    step(2);
    // start+abort together in idle, then a second start while busy is ignored
    wlog.delete();
    fill_abort = 1;
    start_fill(1, 1, 1, 2, 12'h111);
    fill_abort = 0;
    start_fill(9, 9, 9, 9, 12'h222);
    wait_done(20);
    chk("t2b_aborted", fill_aborted, 0);
    chk("t2b_n", wlog.size(), 2);
    if (wlog.size() == 2) chk("t2b_w1", wlog[1], 16'h0102);
    step(2);
    // pen held 3 cycles during a fill
    wlog.delete();
    start_fill(10, 11, 22, 20, 12'h00F);
    step(1);
    pen_req = 1; pen_addr = 16'h0000; pen_data = 12'hABC;
    step(3);
    pen_req = 0;
    wait_done(30);
    for (int x = 10; x <= 11; x++)
      for (int y = 20; y <= 22; y++) begin
        cnt = 0;
        foreach (wlog[i]) if (wlog[i] == {8'(x), 8'(y)}) cnt++;
        chk("t3_pixel_once", cnt, 1);
      end
    cnt = 0;
    foreach (wlog[i]) if (wlog[i] == 16'h0000) cnt++;
    chk("t3_pen_writes", cnt, 3);
    step(2);
    // abort after 10 fill writes
    wlog.delete();
    start_fill(0, 15, 0, 15, 12'h555);
    step(10);
    fill_abort = 1;
    step(1);
    fill_abort = 0;
    @(negedge clk); #1;
    chk("t5_done", fill_done, 1);
    chk("t5_aborted", fill_aborted, 1);
    chk("t5_n", wlog.size(), 10);
    if (wlog.size() == 10) chk("t5_last", wlog[9], 16'h0009);
    wlog.delete();
    step(1);
    start_fill(1, 1, 1, 1, 12'h777);
    wait_done(10);
    chk("t5_restart_n", wlog.size(), 1);
    if (wlog.size() == 1) chk("t5_restart_addr", wlog[0], 16'h0101);
    step(2);
    // full screen
    wlog.delete();
    start_fill(0, 255, 0, 255, 12'h000);
    wait_done(70000);
    chk("t4_aborted", fill_aborted, 0);
    chk("t4_n", wlog.size(), 65536);
    if (wlog.size() > 0) chk("t4_last", wlog[wlog.size()-1], 16'hFFFF);
    step(2);
    // async reset mid-fill
    start_fill(0, 255, 0, 255, 12'hFFF);
    step(5);
    rst = 1;
    #1;
    chk("t6_we", vram_we, 0);
    chk("t6_busy", fill_busy, 0);
    step(2);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("t6_no_done", fill_done, 0);
    end
    wlog.delete();
    step(1);
    start_fill(7, 7, 7, 7, 12'h707);
    wait_done(10);
    chk("t6_n", wlog.size(), 1);
    if (wlog.size() == 1) chk("t6_addr", wlog[0], 16'h0707);
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
